idct_vec_rot_twiddle: RTL and testbench
=======================================

# idct_vec_rot_twiddle

Parametrised rotation-coefficient generator for the IDCT vector-rotation stage, producing one (cos, sin) pair per valid input sample for any power-of-two IDCT length up to 2^wAddr. It stores a single quarter-wave sine table, derives cosine by address mirroring, and supports forward/inverse rotation sign. The block sits beside the vector-rotation multiplier, ahead of the IFFT, and emits coefficients with fixed latency plus frame markers.

## Interface
- wDataOut, 18, signed output width; full scale S = 2^(wDataOut-2)
- wAddr, 11, log2 of maximum length NMAX (NMAX = 2^wAddr)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset, one clock domain
- sink_valid  in  1  one coefficient requested per cycle when high
- sink_sop  in  1  first sample of frame; qualified by sink_valid
- fftpts_in  in  wAddr+1  frame length N, sampled at sop
- inv  in  1  0: sin output positive; 1: sin output negated; sampled at sop
- source_valid  out  1  coefficient pair valid
- source_sop  out  1  pair for k = 0
- source_eop  out  1  pair for k = N-1
- source_idx  out  wAddr  index k of current pair
- source_cos  out  wDataOut  signed cosine coefficient
- source_sin  out  wDataOut  signed sine coefficient
- size_err  out  1  latched length not a power of two in [32, NMAX]

## Operation
- Table: sin_tab[j] = round(S*sin(pi*j/(2*NMAX))), j = 0..NMAX-1, read via two registered read ports.
- Length decode at sink_valid & sink_sop: step = NMAX/N; invalid N -> step = 1 (treated as NMAX), size_err = 1 for that frame; valid N clears size_err.
- Index counter k: 0 on sop; +1 per sink_valid; after N-1 wraps to 0 without sop; holds when sink_valid low.
- Address j = k*step (shift by log2(step)); sin port reads sin_tab[j]; cos port reads sin_tab[NMAX-j], j = 0 forced to S.
- k = 0 (DC): see Configuration.
- inv = 1: source_sin = -sin value (two's complement); cos never negated.
- Arithmetic: all values fit wDataOut signed since max is round(sqrt(2)*S) < 2^(wDataOut-1); no saturation required.
- sop with k != 0 mid-frame restarts at k = 0 and relatches N/inv; previous frame yields no eop.

## Timing
- Pipeline: S1 registers j, flags, valid; S2 ROM registered read; S3 output mux/negate registers.
- Latency: exactly 3 cycles from sink_valid to source_valid, gaps preserved cycle-for-cycle.
- Throughput: one pair per clock, no backpressure.
- source_sop/eop/idx aligned with the pair they describe; eop and sop together when N-1 = 0 is impossible (N >= 32).
- Reset values: all outputs 0; counter, step-latch (NMAX), inv latch, pipeline valids cleared.
- Reset mid-frame: asynchronous clear; first post-reset pair requires no sop (k starts 0) but uses default N = NMAX, inv = 0.
- When source_valid low, data outputs hold last value.

## Configuration
- IDCT_VEC_ROT_DC_SQRT2_EN defined: k = 0 outputs cos = round(sqrt(2)*S), sin = 0 (absorbs 1/w(1) weighting).
- Not defined: k = 0 outputs cos = S, sin = 0; downstream applies the DC weight.

## Test plan
- Reset, then N=2048, inv=0, macro on, 2048 valid cycles -> k=0: cos 92682 sin 0; k=1: cos 65536 sin 50; k=1024: 46341/46341; eop at k=2047, 3 cycles after input.
- N=32, inv=1, macro off -> k=0: 65536/0; k=16: cos 46341 sin -46341; k=1: step 64, sin = -round(65536*sin(pi/64)) = -3216.
- N=1000 at sop -> size_err=1, counter runs to 2047 (NMAX behaviour); next sop N=256 -> size_err=0.
- sink_valid toggled 1,0,1,1,0 -> source_valid same pattern 3 cycles later, idx 0,1,2 without skips.
- Two frames back-to-back N=64 without second sop -> k wraps 63 -> 0, source_sop reasserts on wrap.
- rst_n low mid-frame N=128 k=40 -> outputs 0 immediately; after release, no sop, idx restarts 0 with N=2048.

Source files
------------

// File: rtl/idct_vec_rot_twiddle_if.sv
// rtl/idct_vec_rot_twiddle_if.sv - sink/source bundle for the IDCT rotation twiddle generator.
interface idct_vec_rot_twiddle_if #(
   parameter int wDataOut = 18,
   parameter int wAddr    = 11
);
   logic                       sink_valid;
   logic                       sink_sop;
   logic [wAddr:0]             fftpts_in;
   logic                       inv;
   logic                       source_valid;
   logic                       source_sop;
   logic                       source_eop;
   logic [wAddr-1:0]           source_idx;
   logic signed [wDataOut-1:0] source_cos;
   logic signed [wDataOut-1:0] source_sin;
   logic                       size_err;

   modport slave (
      input  sink_valid, sink_sop, fftpts_in, inv,
      output source_valid, source_sop, source_eop, source_idx, source_cos, source_sin, size_err
   );

   modport master (
      output sink_valid, sink_sop, fftpts_in, inv,
      input  source_valid, source_sop, source_eop, source_idx, source_cos, source_sin, size_err
   );
endinterface

// File: rtl/idct_vec_rot_twiddle.sv
// rtl/idct_vec_rot_twiddle.sv - (cos, sin) twiddle generator for the IDCT vector-rotation stage.
// Optional IDCT_VEC_ROT_DC_SQRT2_EN: the DC pair carries cos = round(sqrt(2)*S).
module idct_vec_rot_twiddle #(
   parameter int wDataOut = 18,
   parameter int wAddr    = 11
) (
   input logic                   clk,
   input logic                   rst_n,
   idct_vec_rot_twiddle_if.slave bus
);
   localparam int  NMAX  = 1 << wAddr;
   localparam int  SHW   = $clog2(wAddr + 1);
   localparam int  S_INT = 1 << (wDataOut - 2);
   localparam real PI    = 3.14159265358979323846;

   function automatic logic signed [wDataOut-1:0] round_s(input real x);
      return wDataOut'($rtoi(x + 0.5));
   endfunction

   function automatic logic signed [wDataOut-1:0] sin_val(input int j);
      return round_s($itor(S_INT) * $sin(PI * $itor(j) / $itor(2 * NMAX)));
   endfunction

   localparam logic signed [wDataOut-1:0] S_VAL = wDataOut'(S_INT);
`ifdef IDCT_VEC_ROT_DC_SQRT2_EN
   localparam logic signed [wDataOut-1:0] DC_COS = round_s($itor(S_INT) * $sqrt(2.0));
`else
   localparam logic signed [wDataOut-1:0] DC_COS = S_VAL;
`endif

   // Quarter-wave sine table; cosine is read from the mirrored address.
   logic signed [wDataOut-1:0] sin_tab [NMAX];
   for (genvar g = 0; g < NMAX; g++) begin : g_tab
      localparam logic signed [wDataOut-1:0] TAB_V = sin_val(g);
      assign sin_tab[g] = TAB_V;
   end

   typedef struct packed {
      logic             valid;
      logic             sop;
      logic             eop;
      logic             inv;
      logic             dc;
      logic [wAddr-1:0] idx;
   } tag_t;

   logic [wAddr-1:0]           k_q, k_d, k_cur, last_k, s1_j_q, s1_j_d, cos_addr;
   logic [SHW-1:0]             sh_q, sh_d, sh_cur, len_sh;
   logic                       inv_q, inv_d, inv_cur, len_ok, sop_in;
   logic                       size_err_q, size_err_d;
   tag_t                       s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
   logic signed [wDataOut-1:0] s2_sin_q, s2_sin_d, s2_cos_q, s2_cos_d;
   logic                       src_valid_q, src_valid_d, src_sop_q, src_sop_d, src_eop_q, src_eop_d;
   logic [wAddr-1:0]           src_idx_q, src_idx_d;
   logic signed [wDataOut-1:0] src_cos_q, src_cos_d, src_sin_q, src_sin_d;

   always_comb begin
      // Only exact powers of two in [32, NMAX] are legal; anything else runs as NMAX.
      len_ok = 1'b0;
      len_sh = '0;
      for (int b = 5; b <= wAddr; b++) begin
         if (bus.fftpts_in == ((wAddr + 1)'(1) << b)) begin
            len_ok = 1'b1;
            len_sh = SHW'(wAddr - b);
         end
      end

      sop_in  = bus.sink_valid & bus.sink_sop;
      k_cur   = sop_in ? '0 : k_q;
      sh_cur  = sop_in ? len_sh : sh_q;
      inv_cur = sop_in ? bus.inv : inv_q;
      last_k  = {wAddr{1'b1}} >> sh_cur;

      k_d        = k_q;
      sh_d       = sh_q;
      inv_d      = inv_q;
      size_err_d = size_err_q;
      if (bus.sink_valid) begin
         k_d   = (k_cur == last_k) ? '0 : k_cur + 1'b1;
         sh_d  = sh_cur;
         inv_d = inv_cur;
         if (sop_in) size_err_d = ~len_ok;
      end

      s1_j_d         = k_cur << sh_cur;
      s1_tag_d.valid = bus.sink_valid;
      s1_tag_d.sop   = (k_cur == '0);
      s1_tag_d.eop   = (k_cur == last_k);
      s1_tag_d.inv   = inv_cur;
      s1_tag_d.dc    = (k_cur == '0);
      s1_tag_d.idx   = k_cur;

      cos_addr = -s1_j_q;
      s2_tag_d = s1_tag_q;
      s2_sin_d = sin_tab[s1_j_q];
      s2_cos_d = (s1_j_q == '0) ? S_VAL : sin_tab[cos_addr];

      src_valid_d = s2_tag_q.valid;
      src_sop_d   = s2_tag_q.valid & s2_tag_q.sop;
      src_eop_d   = s2_tag_q.valid & s2_tag_q.eop;
      src_idx_d   = src_idx_q;
      src_cos_d   = src_cos_q;
      src_sin_d   = src_sin_q;
      if (s2_tag_q.valid) begin
         src_idx_d = s2_tag_q.idx;
         src_cos_d = s2_tag_q.dc ? DC_COS : s2_cos_q;
         src_sin_d = s2_tag_q.dc ? '0 : (s2_tag_q.inv ? -s2_sin_q : s2_sin_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q         <= '0;
         sh_q        <= '0;
         inv_q       <= 1'b0;
         size_err_q  <= 1'b0;
         s1_j_q      <= '0;
         s1_tag_q    <= '0;
         s2_tag_q    <= '0;
         s2_sin_q    <= '0;
         s2_cos_q    <= '0;
         src_valid_q <= 1'b0;
         src_sop_q   <= 1'b0;
         src_eop_q   <= 1'b0;
         src_idx_q   <= '0;
         src_cos_q   <= '0;
         src_sin_q   <= '0;
      end else begin
         k_q         <= k_d;
         sh_q        <= sh_d;
         inv_q       <= inv_d;
         size_err_q  <= size_err_d;
         s1_j_q      <= s1_j_d;
         s1_tag_q    <= s1_tag_d;
         s2_tag_q    <= s2_tag_d;
         s2_sin_q    <= s2_sin_d;
         s2_cos_q    <= s2_cos_d;
         src_valid_q <= src_valid_d;
         src_sop_q   <= src_sop_d;
         src_eop_q   <= src_eop_d;
         src_idx_q   <= src_idx_d;
         src_cos_q   <= src_cos_d;
         src_sin_q   <= src_sin_d;
      end
   end

   assign bus.source_valid = src_valid_q;
   assign bus.source_sop   = src_sop_q;
   assign bus.source_eop   = src_eop_q;
   assign bus.source_idx   = src_idx_q;
   assign bus.source_cos   = src_cos_q;
   assign bus.source_sin   = src_sin_q;
   assign bus.size_err     = size_err_q;
endmodule

// File: tb/tb_idct_vec_rot_twiddle.sv
// tb/tb_idct_vec_rot_twiddle.sv - scoreboard and vector bench for idct_vec_rot_twiddle.
module tb_idct_vec_rot_twiddle;
   localparam int  W    = 18;
   localparam int  A    = 11;
   localparam int  NMAX = 2048;
   localparam int  S    = 65536;
   localparam real PI   = 3.14159265358979323846;
`ifdef IDCT_VEC_ROT_DC_SQRT2_EN
   localparam int  DC_COS = 92682;
`else
   localparam int  DC_COS = S;
`endif

   typedef struct {
      int idx;
      int c;
      int s;
      int sop;
      int eop;
   } exp_t;

   typedef struct {
      int n;
      bit inv;
      int k;
      int cos_e;
      int sin_e;
   } spot_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   idct_vec_rot_twiddle_if #(.wDataOut(W), .wAddr(A)) bus ();
   idct_vec_rot_twiddle #(.wDataOut(W), .wAddr(A)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int   tests = 0;
   int   fails = 0;
   exp_t sbq[$];
   exp_t mon_e;
   logic [2:0] vhist = '0;
   int   last_idx = -1, last_c = 0, last_s = 0;
   int   sop_cnt = 0, eop_cnt = 0;
   int   m_k = 0, m_n = NMAX;
   bit   m_inv = 1'b0;
   spot_t spots [7];

   task automatic check(string name, int tag, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s tag=%0d actual=%0d expected=%0d", name, tag, act, exp);
      end
   endtask

   function automatic int rnd(real x);
      return $rtoi(x + 0.5);
   endfunction

   function automatic bit len_legal(int n);
      return (n >= 32) && (n <= NMAX) && ((n & (n - 1)) == 0);
   endfunction

   task automatic drive(bit v, bit sop, int n, bit inv_i);
      exp_t e;
      int   j;
      @(posedge clk);
      #1;
      bus.sink_valid = v;
      bus.sink_sop   = sop;
      bus.fftpts_in  = 12'(n);
      bus.inv        = inv_i;
      if (v) begin
         if (sop) begin
            m_k   = 0;
            m_n   = len_legal(n) ? n : NMAX;
            m_inv = inv_i;
         end
         j     = m_k * (NMAX / m_n);
         e.idx = m_k;
         e.sop = (m_k == 0);
         e.eop = (m_k == m_n - 1);
         if (m_k == 0) begin
            e.c = DC_COS;
            e.s = 0;
         end else begin
            e.c = rnd(S * $sin(PI * (NMAX - j) / (2.0 * NMAX)));
            e.s = rnd(S * $sin(PI * j / (2.0 * NMAX)));
            if (m_inv) e.s = -e.s;
         end
         sbq.push_back(e);
         m_k = (m_k == m_n - 1) ? 0 : m_k + 1;
      end
   endtask

   task automatic idle(int cycles);
      for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 0, 1'b0);
   endtask

   // Non-sop samples carry junk length/inv that the DUT must ignore.
   task automatic frame(int n, bit inv_i, int cnt);
      drive(1'b1, 1'b1, n, inv_i);
      for (int i = 1; i < cnt; i++) drive(1'b1, 1'b0, 0, ~inv_i);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         vhist = '0;
         sbq.delete();
      end else begin
         check("source_valid", -1, int'(bus.source_valid), int'(vhist[2]));
         if (bus.source_valid) begin
            if (sbq.size() == 0) begin
               check("sb_underflow", int'(bus.source_idx), sbq.size(), 1);
            end else begin
               mon_e = sbq.pop_front();
               check("idx", mon_e.idx, int'(bus.source_idx), mon_e.idx);
               check("cos", mon_e.idx, int'(bus.source_cos), mon_e.c);
               check("sin", mon_e.idx, int'(bus.source_sin), mon_e.s);
               check("sop", mon_e.idx, int'(bus.source_sop), mon_e.sop);
               check("eop", mon_e.idx, int'(bus.source_eop), mon_e.eop);
            end
            last_idx = int'(bus.source_idx);
            last_c   = int'(bus.source_cos);
            last_s   = int'(bus.source_sin);
            if (bus.source_sop) sop_cnt++;
            if (bus.source_eop) eop_cnt++;
         end
         vhist = {vhist[1:0], bus.sink_valid};
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      int s0;
      spots[0] = '{n: 2048, inv: 1'b0, k: 0,    cos_e: DC_COS, sin_e: 0};
      spots[1] = '{n: 2048, inv: 1'b0, k: 1,    cos_e: 65536,  sin_e: 50};
      spots[2] = '{n: 2048, inv: 1'b0, k: 1024, cos_e: 46341,  sin_e: 46341};
      spots[3] = '{n: 32,   inv: 1'b1, k: 0,    cos_e: DC_COS, sin_e: 0};
      spots[4] = '{n: 32,   inv: 1'b1, k: 16,   cos_e: 46341,  sin_e: -46341};
      spots[5] = '{n: 32,   inv: 1'b1, k: 1,    cos_e: 65457,  sin_e: -3216};
      spots[6] = '{n: 256,  inv: 1'b0, k: 64,   cos_e: 60547,  sin_e: 25080};

      bus.sink_valid = 1'b0;
      bus.sink_sop   = 1'b0;
      bus.fftpts_in  = '0;
      bus.inv        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 0, int'(bus.source_valid), 0);
      check("rst_sop", 0, int'(bus.source_sop), 0);
      check("rst_eop", 0, int'(bus.source_eop), 0);
      check("rst_idx", 0, int'(bus.source_idx), 0);
      check("rst_cos", 0, int'(bus.source_cos), 0);
      check("rst_sin", 0, int'(bus.source_sin), 0);
      check("rst_size_err", 0, int'(bus.size_err), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         frame(spots[i].n, spots[i].inv, spots[i].k + 1);
         idle(5);
         check("spot_idx", i, last_idx, spots[i].k);
         check("spot_cos", i, last_c, spots[i].cos_e);
         check("spot_sin", i, last_s, spots[i].sin_e);
      end

      e0 = eop_cnt;
      frame(2048, 1'b0, 2048);
      idle(5);
      check("full_frame_eops", 2048, eop_cnt - e0, 1);
      check("full_frame_last_idx", 2048, last_idx, 2047);

      e0 = eop_cnt;
      frame(1000, 1'b0, 2050);
      idle(3);
      check("size_err_set", 1000, int'(bus.size_err), 1);
      check("bad_len_eops", 1000, eop_cnt - e0, 1);
      frame(256, 1'b0, 4);
      idle(5);
      check("size_err_clear", 256, int'(bus.size_err), 0);

      drive(1'b1, 1'b1, 64, 1'b0);
      drive(1'b0, 1'b0, 0, 1'b0);
      drive(1'b1, 1'b0, 0, 1'b1);
      drive(1'b1, 1'b0, 0, 1'b1);
      drive(1'b0, 1'b0, 0, 1'b0);
      idle(5);
      check("gap_last_idx", 64, last_idx, 2);

      s0 = sop_cnt;
      e0 = eop_cnt;
      frame(64, 1'b1, 128);
      idle(5);
      check("wrap_sops", 64, sop_cnt - s0, 2);
      check("wrap_eops", 64, eop_cnt - e0, 2);

      frame(128, 1'b0, 41);
      @(posedge clk);
      #1;
      bus.sink_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 40, int'(bus.source_valid), 0);
      check("midrst_idx", 40, int'(bus.source_idx), 0);
      check("midrst_cos", 40, int'(bus.source_cos), 0);
      check("midrst_sin", 40, int'(bus.source_sin), 0);
      m_k   = 0;
      m_n   = NMAX;
      m_inv = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 64, 1'b1);
      idle(5);
      check("post_rst_idx", 4, last_idx, 4);
      check("post_rst_sin", 4, last_s, rnd(S * $sin(PI * 4 / (2.0 * NMAX))));

      idle(6);
      check("sb_empty", 0, sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
